// File: rtl/aer_pkg.sv
// Shared definitions for the AER receive controller: FSM states, default
// parameters and event-word field layout.
package aer_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned SETTLE_DEF     = 2;
  localparam int unsigned TS_W_DEF       = 8;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned ADDRY_LSB = 0;
  localparam int unsigned ADDRX_LSB = ADDRY_LSB + ADDR_W;
  localparam int unsigned TS_LSB    = ADDRX_LSB + ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT_SPACE,
    ST_ACK_HI,
    ST_ACK_LO
  } rx_state_t;

endpackage

// File: rtl/aer_rx_ctrl_if.sv
// AER handshake plus event-stream bundle; slave is the receiver side.
interface aer_rx_ctrl_if #(
  parameter int unsigned TS_W       = 8,
  parameter int unsigned FIFO_DEPTH = 8
);
  logic                          REQ;
  logic [3:0]                    ADDRY;
  logic [3:0]                    ADDRX;
  logic                          ACK;
  logic                          AER_DIS;
  logic                          EVT_VALID;
  logic                          EVT_READY;
  logic [TS_W+7:0]               EVT_DATA;
  logic [$clog2(FIFO_DEPTH):0]   LEVEL;

  modport slave (
    input  REQ, ADDRY, ADDRX, EVT_READY,
    output ACK, AER_DIS, EVT_VALID, EVT_DATA, LEVEL
  );

  modport master (
    output REQ, ADDRY, ADDRX, EVT_READY,
    input  ACK, AER_DIS, EVT_VALID, EVT_DATA, LEVEL
  );
endinterface

// File: rtl/aer_evt_fifo.sv
// Synchronous first-word-fall-through event FIFO with occupancy output.
module aer_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  output logic                     valid,
  output logic [W-1:0]             data,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          full;
  logic          wr_en;

  assign valid = (level != '0);
  assign data  = mem[rd_ptr];
  assign pop   = valid & ready;
  assign full  = (level == LW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(pop);
    end
  end

endmodule

// File: rtl/aer_rx_ctrl.sv
// AER 4-phase receiver: synchronizes REQ, lets the address bus settle,
// timestamps and queues events, and applies backpressure via ACK and AER_DIS.
module aer_rx_ctrl
  import aer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned SETTLE     = SETTLE_DEF,
  parameter int unsigned TS_W       = TS_W_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  aer_rx_ctrl_if.slave  aer
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = TS_W + 2 * ADDR_W;
  localparam int unsigned CW = 4;

  rx_state_t       state;
  logic            req_meta;
  logic            req_s;
  logic [CW-1:0]   settle_cnt;
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_lat;
  logic            ack_q;
  logic            aer_dis_q;

  logic            fifo_valid;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_nxt;
  logic            pop;
  logic            full;
  logic            can_push;
  logic            push;
  logic [EW-1:0]   push_data;

  assign pop       = fifo_valid & aer.EVT_READY;
  assign full      = (level == LW'(FIFO_DEPTH));
  assign can_push  = ~full | pop;
  assign push      = can_push & ((state == ST_SETTLE && settle_cnt == '0) ||
                                 (state == ST_WAIT_SPACE));
  assign push_data = {ts_lat, aer.ADDRX, aer.ADDRY};
  assign level_nxt = level + LW'(push) - LW'(pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_meta   <= 1'b0;
      req_s      <= 1'b0;
      ts_cnt     <= '0;
      ts_lat     <= '0;
      settle_cnt <= '0;
      ack_q      <= 1'b0;
      aer_dis_q  <= 1'b1;
      state      <= ST_IDLE;
    end else begin
      req_meta  <= aer.REQ;
      req_s     <= req_meta;
      ts_cnt    <= ts_cnt + TS_W'(1);
      aer_dis_q <= (level_nxt >= LW'(FIFO_DEPTH - 1)) | ~EN;
      unique case (state)
        ST_IDLE: begin
          if (req_s && EN) begin
            state      <= ST_SETTLE;
            settle_cnt <= CW'(SETTLE - 1);
            ts_lat     <= ts_cnt;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            if (can_push) begin
              state <= ST_ACK_HI;
              ack_q <= 1'b1;
            end else begin
              state <= ST_WAIT_SPACE;
            end
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        ST_WAIT_SPACE: begin
          if (can_push) begin
            state <= ST_ACK_HI;
            ack_q <= 1'b1;
          end
        end
        ST_ACK_HI: begin
          if (!req_s) begin
            state <= ST_ACK_LO;
            ack_q <= 1'b0;
          end
        end
        ST_ACK_LO: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Gating with req_s releases ACK as soon as the synchronized REQ falls,
  // one cycle ahead of the registered ACK_HI->ACK_LO transition.
  assign aer.ACK     = ack_q & req_s;
  assign aer.AER_DIS = aer_dis_q;
  assign aer.EVT_VALID = fifo_valid;

  aer_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .valid     (fifo_valid),
    .data      (aer.EVT_DATA),
    .ready     (aer.EVT_READY),
    .level     (level)
  );

  assign aer.LEVEL = level;

endmodule
